// File: rtl/skinny_dom1_pkg.sv
// Shared types and constants for the first-order DOM masked SKINNY-128-384+ datapath.
package skinny_dom1_pkg;

  // The external DOM sbox8 is non-pipelined and spends one cycle per layer.
  localparam int SBOX_LAT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } sc_state_e;

  typedef struct packed {
    logic [7:0] s1;
    logic [7:0] s0;
  } share_byte_t;

endpackage

// File: rtl/skinny_dom1_phase_seq.sv
// Phase/byte counters for the byte-serial SubCells pass and one-hot sbox layer enables.
module skinny_dom1_phase_seq
  import skinny_dom1_pkg::*;
#(
  parameter int NBYTES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                run,
  output logic [SBOX_LAT-1:0] sb_en,
  output logic                ph_first,
  output logic                ph_last,
  output logic                bc_first,
  output logic                bc_last
);

  localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [1:0]     ph;
  logic [BCW-1:0] bc;

  assign ph_first = (ph == 2'd0);
  assign ph_last  = (ph == 2'(SBOX_LAT - 1));
  assign bc_first = (bc == '0);
  assign bc_last  = (bc == BCW'(NBYTES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ph <= '0;
      bc <= '0;
    end else if (run) begin
      ph <= ph + 2'd1;
      if (ph_last) bc <= bc + BCW'(1);
    end
  end

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    sb_en = '0;
    if (run) sb_en[ph] = 1'b1;
  end

endmodule

// File: rtl/skinny_subcells_dom1_serial.sv
// Byte-serial SubCells sequencer feeding an external 4-cycle DOM sbox8, MSB byte first.
// Optional build macro SKINNY_SC_IDLE_ZERO_EN: zero sbox inputs outside RUN, clear state after DONE.
module skinny_subcells_dom1_serial
  import skinny_dom1_pkg::*;
#(
  parameter int NBYTES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] si1,
  input  logic [8*NBYTES-1:0] si0,
  input  logic [7:0]          rnd,
  output logic                rnd_ack,
  output logic [7:0]          sb_si1,
  output logic [7:0]          sb_si0,
  output logic [7:0]          sb_r,
  output logic [3:0]          sb_en,
  input  logic [7:0]          sb_bo1,
  input  logic [7:0]          sb_bo0,
  output logic [8*NBYTES-1:0] so1,
  output logic [8*NBYTES-1:0] so0,
  output logic                busy,
  output logic                done
);

  localparam int W = 8 * NBYTES;

  sc_state_e   state, state_nxt;
  logic [W-1:0] sh1, sh0;
  logic [7:0]   r_hold;
  logic         load, run;
  logic         ph_first, ph_last, bc_first, bc_last;
  share_byte_t  top_byte;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_RUN;
      ST_RUN:   if (ph_last && bc_last) state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load    = (state == ST_LOAD);
    run     = (state == ST_RUN);
    busy    = (state != ST_IDLE);
    done    = (state == ST_DONE);
    // The last byte needs no fresh mask, so exactly NBYTES masks are drawn per pass.
    rnd_ack = load || (run && ph_last && !bc_last);
  end

  skinny_dom1_phase_seq #(
    .NBYTES (NBYTES)
  ) u_phase_seq (
    .clk      (clk),
    .rst      (rst),
    .clear    (load),
    .run      (run),
    .sb_en    (sb_en),
    .ph_first (ph_first),
    .ph_last  (ph_last),
    .bc_first (bc_first),
    .bc_last  (bc_last)
  );

  // Results of byte bc-1 enter at the bottom and ride the shift up to their original cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh1    <= '0;
      sh0    <= '0;
      r_hold <= '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          sh1    <= si1;
          sh0    <= si0;
          r_hold <= rnd;
        end
        ST_RUN: begin
          if (ph_first && !bc_first) begin
            sh1[7:0] <= sb_bo1;
            sh0[7:0] <= sb_bo0;
          end
          if (ph_last) begin
            sh1 <= sh1 << 8;
            sh0 <= sh0 << 8;
            if (!bc_last) r_hold <= rnd;
          end
        end
        ST_FLUSH: begin
          sh1[7:0] <= sb_bo1;
          sh0[7:0] <= sb_bo0;
        end
`ifdef SKINNY_SC_IDLE_ZERO_EN
        ST_DONE: begin
          sh1 <= '0;
          sh0 <= '0;
        end
`endif
        default: ;
      endcase
    end
  end

  assign top_byte = '{s1: sh1[W-1 -: 8], s0: sh0[W-1 -: 8]};

`ifdef SKINNY_SC_IDLE_ZERO_EN
  assign sb_si1 = run ? top_byte.s1 : 8'h00;
  assign sb_si0 = run ? top_byte.s0 : 8'h00;
  assign sb_r   = run ? r_hold      : 8'h00;
`else
  assign sb_si1 = top_byte.s1;
  assign sb_si0 = top_byte.s0;
  assign sb_r   = r_hold;
`endif

  assign so1 = sh1;
  assign so0 = sh0;

endmodule

// File: tb/tb_skinny_subcells_dom1_serial.sv
// Self-checking bench: behavioural DOM sbox8 model on the sb_* ports, random shares and masks.
module tb_skinny_subcells_dom1_serial;

  localparam int NB = 16;
  localparam int W  = 8 * NB;
  localparam int LAT = 4 * NB + 3;

  logic         clk, rst, start;
  logic [W-1:0] si1, si0, so1, so0;
  logic [7:0]   rnd, sb_si1, sb_si0, sb_r, sb_bo1, sb_bo0;
  logic [3:0]   sb_en;
  logic         rnd_ack, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  skinny_subcells_dom1_serial #(.NBYTES(NB)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .si1     (si1),
    .si0     (si0),
    .rnd     (rnd),
    .rnd_ack (rnd_ack),
    .sb_si1  (sb_si1),
    .sb_si0  (sb_si0),
    .sb_r    (sb_r),
    .sb_en   (sb_en),
    .sb_bo1  (sb_bo1),
    .sb_bo0  (sb_bo0),
    .so1     (so1),
    .so0     (so0),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 rnd = 8'($urandom);
    end
  end

  // SKINNY 8-bit sbox from its NOR/XOR + bit-permutation description.
  function automatic logic [7:0] sbox8(input logic [7:0] xin);
    logic [7:0] x, y;
    x = xin;
    for (int r = 0; r < 4; r++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (r < 3) y = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
      else       y = {x[7], x[6], x[5], x[4], x[3], x[1], x[2], x[0]};
      x = y;
    end
    return x;
  endfunction

  function automatic logic [W-1:0] sc_ref(input logic [W-1:0] x);
    logic [W-1:0] o;
    for (int i = 0; i < NB; i++) o[8*i +: 8] = sbox8(x[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [W-1:0] rand_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // DOM sbox8 model: captures inputs on layer 0, registers masked output on layer 3.
  logic [7:0] m_x1, m_x0, m_r, last_acked;
  initial begin
    sb_bo1 = 8'h00;
    sb_bo0 = 8'h00;
    last_acked = 8'h00;
  end

  always @(posedge clk) begin
    if (sb_en[0]) begin
      m_x1 <= sb_si1;
      m_x0 <= sb_si0;
      m_r  <= sb_r;
    end
    if (sb_en[3]) begin
      sb_bo1 <= sbox8(m_x1 ^ m_x0) ^ m_r;
      sb_bo0 <= m_r;
    end
  end

  // Inputs and mask must hold for all four layers; the mask must be the latest one acknowledged.
  always @(posedge clk) begin
    if (sb_en[0] === 1'b1) begin
      n_checks++;
      if (sb_r !== last_acked) begin
        n_fail++;
        $display("FAIL mask_src: sb_r=%h expected last acked rnd %h", sb_r, last_acked);
      end
    end
    if (sb_en[3:1] !== 3'b000 && sb_en !== 4'bx) begin
      n_checks++;
      if (sb_si1 !== m_x1 || sb_si0 !== m_x0 || sb_r !== m_r) begin
        n_fail++;
        $display("FAIL hold: en=%b got %h/%h/%h expected %h/%h/%h",
                 sb_en, sb_si1, sb_si0, sb_r, m_x1, m_x0, m_r);
      end
    end
    if (rnd_ack === 1'b1) last_acked = rnd;
  end

  // One full operation started in the cycle after the call; extra_start pulses start mid-run.
  task automatic run_op(input string tag, input logic [W-1:0] a1, input logic [W-1:0] a0,
                        input int extra_start, output logic [W-1:0] res);
    logic [W-1:0] exp_x;
    logic [3:0]   exp_en;
    int lat, acks;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_pre: busy=%b done=%b expected 0/0", tag, busy, done);
    end
    si1 = a1;
    si0 = a0;
    start = 1'b1;
    exp_x = sc_ref(a1 ^ a0);
    lat = 0;
    acks = 0;
    res = '0;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(posedge clk); #1;
      start = (k == extra_start);
      if (k == 2) begin
        si1 = rand_w();
        si0 = rand_w();
      end
      exp_en = (k >= 2 && k <= 4 * NB + 1) ? 4'(1 << ((k - 2) % 4)) : 4'b0000;
      n_checks++;
      if (sb_en !== exp_en) begin
        n_fail++;
        $display("FAIL %s sb_en c%0d: got %b expected %b", tag, k, sb_en, exp_en);
      end
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy c%0d: got %b expected 1", tag, k, busy);
      end
      if (rnd_ack === 1'b1) acks++;
      if (done === 1'b1) begin
        lat = k;
        res = so1 ^ so0;
      end
    end
    start = 1'b0;
    n_checks++;
    if (lat != LAT) begin
      n_fail++;
      $display("FAIL %s latency: done at cycle %0d expected %0d", tag, lat, LAT);
    end
    n_checks++;
    if (acks != NB) begin
      n_fail++;
      $display("FAIL %s rnd_ack count: got %0d expected %0d", tag, acks, NB);
    end
    n_checks++;
    if (res !== exp_x) begin
      n_fail++;
      $display("FAIL %s result: got %h expected %h", tag, res, exp_x);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    si1 = '0;
    si0 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rnd_ack !== 1'b0 || sb_en !== 4'b0) begin
      n_fail++;
      $display("FAIL reset ctrl: busy=%b done=%b ack=%b en=%b expected 0", busy, done, rnd_ack, sb_en);
    end
    n_checks++;
    if (so1 !== '0 || so0 !== '0 || sb_si1 !== 8'h00 || sb_si0 !== 8'h00 || sb_r !== 8'h00) begin
      n_fail++;
      $display("FAIL reset data: so1=%h so0=%h sb=%h/%h/%h expected 0", so1, so0, sb_si1, sb_si0, sb_r);
    end
  endtask

  task automatic test_zero_state();
    logic [W-1:0] res;
    run_op("zero", '0, '0, 0, res);
    n_checks++;
    if (res !== {NB{8'h65}}) begin
      n_fail++;
      $display("FAIL zero const: got %h expected %h", res, {NB{8'h65}});
    end
  endtask

  task automatic test_all_ones();
    logic [W-1:0] res, r0;
    run_op("ones", '0, '1, 0, res);
    n_checks++;
    if (res !== '1) begin
      n_fail++;
      $display("FAIL ones const: got %h expected all ff", res);
    end
    r0 = rand_w();
    run_op("ones_masked", r0, r0 ^ '1, 0, res);
    n_checks++;
    if (res !== '1) begin
      n_fail++;
      $display("FAIL ones_masked const: got %h expected all ff", res);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] res;
    for (int i = 0; i < 3; i++) run_op("random", rand_w(), rand_w(), 0, res);
  endtask

  task automatic test_reset_mid();
    int dones;
    logic [W-1:0] res;
    @(posedge clk); #1;
    si1 = rand_w();
    si0 = rand_w();
    start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || sb_en !== 4'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid ctrl: busy=%b en=%b done=%b expected 0", busy, sb_en, done);
    end
    n_checks++;
    if (so1 !== '0 || so0 !== '0) begin
      n_fail++;
      $display("FAIL rst_mid data: so1=%h so0=%h expected 0", so1, so0);
    end
    dones = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL rst_mid done: got %0d pulses expected 0", dones);
    end
    run_op("after_rst", rand_w(), rand_w(), 0, res);
  endtask

  task automatic test_start_filter();
    int dones;
    logic [W-1:0] res;
    run_op("start_busy", rand_w(), rand_w(), 10, res);
    dones = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL start_busy extra done: got %0d pulses expected 0", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res;
    run_op("b2b_first", rand_w(), rand_w(), 0, res);
    run_op("b2b_second", rand_w(), rand_w(), 0, res);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    si1 = '0;
    si0 = '0;
    rnd = 8'h00;
    test_reset();
    test_zero_state();
    test_all_ones();
    test_random();
    test_reset_mid();
    test_start_filter();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
